// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode encodings, addressing-mode constant and the
// fetch-stage state encoding used by ifetch.
package sisc_pkg;

    localparam logic [3:0] NOOP   = 4'd0;
    localparam logic [3:0] LOD    = 4'd1;
    localparam logic [3:0] STR    = 4'd2;
    localparam logic [3:0] SWP    = 4'd3;
    localparam logic [3:0] BRA    = 4'd4;
    localparam logic [3:0] BRR    = 4'd5;
    localparam logic [3:0] BNE    = 4'd6;
    localparam logic [3:0] BNR    = 4'd7;
    localparam logic [3:0] ALU_OP = 4'd8;
    localparam logic [3:0] HLT    = 4'd15;

    localparam logic [3:0] AM_IMM = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface ifetch_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
);
    logic               im_req;
    logic [PC_W-1:0]    im_addr;
    logic               im_ack;
    logic [INSTR_W-1:0] im_data;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_data
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_data
    );
endinterface

// File: rtl/ifetch_br_cond.sv
// Branch condition and target evaluation for the instruction held in IR.
// Purely combinational; relative targets wrap modulo 2^PC_W.
module br_cond
    import sisc_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [3:0]      opcode,
    input  logic [3:0]      mm,
    input  logic [3:0]      stat,
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     imm,
    output logic            is_branch,
    output logic            taken,
    output logic [PC_W-1:0] target
);

    logic hit_s;

    // Decode branch opcode, condition sense and target kind
    always_comb begin
        hit_s     = |(stat & mm);
        is_branch = 1'b0;
        taken     = 1'b0;
        target    = pc;
        case (opcode)
            BRA: begin
                is_branch = 1'b1;
                taken     = hit_s;
                target    = PC_W'(imm);
            end
            BRR: begin
                is_branch = 1'b1;
                taken     = hit_s;
                target    = pc + PC_W'(imm);
            end
            BNE: begin
                is_branch = 1'b1;
                taken     = ~hit_s;
                target    = PC_W'(imm);
            end
            BNR: begin
                is_branch = 1'b1;
                taken     = ~hit_s;
                target    = pc + PC_W'(imm);
            end
            default: begin
                is_branch = 1'b0;
                taken     = 1'b0;
                target    = pc;
            end
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// SISC instruction-fetch stage: owns PC and IR, fetches over the im_* handshake
// and applies branches. Optional REQ watchdog enabled by IFETCH_TIMEOUT_EN.
module ifetch
    import sisc_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               fetch_go,
    input  logic               br_go,
    input  logic [3:0]         stat,
    ifetch_if.master           im,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic               ir_valid,
    output logic [PC_W-1:0]    pc,
    output logic               br_taken,
    output logic               busy,
    output logic               halted,
    output logic               fetch_err
);

    ifetch_state_e      state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic               br_taken_q, br_taken_d;
    logic               halted_q, halted_d;
    logic               pending_q, pending_d;

    logic               br_is_s;
    logic               br_tk_s;
    logic [PC_W-1:0]    br_tgt_s;

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       fetch_err_q, fetch_err_d;
`endif

    br_cond #(.PC_W(PC_W)) u_br_cond (
        .opcode    (ir_q[31:28]),
        .mm        (ir_q[27:24]),
        .stat      (stat),
        .pc        (pc_q),
        .imm       (ir_q[15:0]),
        .is_branch (br_is_s),
        .taken     (br_tk_s),
        .target    (br_tgt_s)
    );

    // Next-state, PC/IR update and strobe generation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        br_taken_d = 1'b0;
        halted_d   = halted_q;
        pending_d  = pending_q;
`ifdef IFETCH_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (br_go && br_is_s && br_tk_s) begin
                    pc_d       = br_tgt_s;
                    br_taken_d = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
                // A fetch racing a branch is deferred one cycle so it uses the new PC
                if (!halted_q && fetch_go && br_go) begin
                    pending_d = 1'b1;
                end else if (!halted_q && (fetch_go || pending_q)) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
                    to_cnt_d  = 8'd0;
`endif
                end else begin
                    pending_d = pending_q;
                end
            end
            REQ: begin
                if (im.im_ack) begin
                    ir_d       = im.im_data;
                    pc_d       = pc_q + PC_W'(1);
                    ir_valid_d = 1'b1;
                    state_d    = IDLE;
                    if (im.im_data[31:28] == HLT) begin
                        halted_d = 1'b1;
                    end else begin
                        halted_d = halted_q;
                    end
`ifdef IFETCH_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`else
                end else begin
                    state_d = REQ;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch-stage state registers
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            halted_q   <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            br_taken_q <= br_taken_d;
            halted_q   <= halted_d;
            pending_q  <= pending_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    // Request watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            to_cnt_q    <= 8'd0;
            fetch_err_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign im.im_req  = (state_q == REQ);
    assign im.im_addr = pc_q;
    assign busy       = (state_q == REQ);
    assign ir         = ir_q;
    assign opcode     = ir_q[31:28];
    assign mm         = ir_q[27:24];
    assign ir_valid   = ir_valid_q;
    assign pc         = pc_q;
    assign br_taken   = br_taken_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: branch vector table plus
// hand-written fetch, pending-fetch, halt, reset and timeout sequences.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_go;
    logic        br_go;
    logic [3:0]  stat;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic        ir_valid;
    logic [15:0] pc;
    logic        br_taken;
    logic        busy;
    logic        halted;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nvalid   = 0;
    int ntaken   = 0;
    int last_valid_cyc = 0;

    ifetch_if #(.PC_W(16), .INSTR_W(32)) im ();

    ifetch #(.PC_W(16), .INSTR_W(32), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .fetch_go  (fetch_go),
        .br_go     (br_go),
        .stat      (stat),
        .im        (im),
        .ir        (ir),
        .opcode    (opcode),
        .mm        (mm),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .br_taken  (br_taken),
        .busy      (busy),
        .halted    (halted),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pre_pc;
        logic [31:0] instr;
        logic [3:0]  stat;
        logic [15:0] exp_pc;
        int          exp_taken;
    } br_vec_t;

    br_vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // advance one clock and sample outputs 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ir_valid) begin
            nvalid++;
            last_valid_cyc = cyc;
        end
        if (br_taken) ntaken++;
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        fetch_go = 1'b0;
        br_go = 1'b0;
        stat = 4'h0;
        im.im_ack = 1'b0;
        im.im_data = 32'h0;
        step();
        step();
        rst_f = 1'b1;
    endtask

    task automatic do_fetch(input logic [31:0] w, input int waits);
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        repeat (waits) step();
        im.im_ack = 1'b1;
        im.im_data = w;
        step();
        im.im_ack = 1'b0;
        im.im_data = 32'h0;
    endtask

    task automatic do_branch(input logic [3:0] s);
        stat = s;
        br_go = 1'b1;
        step();
        br_go = 1'b0;
        step();
    endtask

    task automatic goto_pc(input logic [15:0] p);
        if (p != 16'h0) begin
            do_fetch({16'h4F00, p}, 0);
            do_branch(4'hF);
        end
    endtask

    initial begin
        int c0;
        int n0;
        int req_cycles;

        vecs[0] = '{16'h0000, 32'h4200_0040, 4'h2, 16'h0040, 1};
        vecs[1] = '{16'h0000, 32'h4200_0040, 4'h1, 16'h0001, 0};
        vecs[2] = '{16'h000F, 32'h7100_FFF0, 4'h0, 16'h0000, 1};
        vecs[3] = '{16'h000F, 32'h7100_FFF0, 4'h1, 16'h0010, 0};
        vecs[4] = '{16'h0020, 32'h5300_0005, 4'h2, 16'h0026, 1};
        vecs[5] = '{16'h0000, 32'h6400_0080, 4'h3, 16'h0080, 1};
        vecs[6] = '{16'h0000, 32'h6400_0080, 4'h4, 16'h0001, 0};
        vecs[7] = '{16'h0000, 32'h8F00_0050, 4'hF, 16'h0001, 0};
        vecs[8] = '{16'hFFFF, 32'h1000_0000, 4'hF, 16'h0000, 0};

        // reset state
        do_reset();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", 32'(im.im_req), 32'h0);
        chk("rst_flags", {28'h0, ir_valid, br_taken, halted, fetch_err}, 32'h0);

        // basic fetch with two wait cycles; a stray fetch_go in REQ is ignored
        c0 = cyc;
        n0 = nvalid;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("f_req", 32'(im.im_req), 32'h1);
        chk("f_busy", 32'(busy), 32'h1);
        chk("f_addr", 32'(im.im_addr), 32'h0);
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        step();
        im.im_ack = 1'b1;
        im.im_data = 32'h1800_0005;
        step();
        im.im_ack = 1'b0;
        im.im_data = 32'h0;
        chk("f_ir", ir, 32'h1800_0005);
        chk("f_pc", 32'(pc), 32'h1);
        chk("f_opmm", {24'h0, opcode, mm}, 32'h18);
        chk("f_valid_at", 32'(last_valid_cyc - c0), 32'd4);
        step();
        step();
        chk("f_valid_cnt", 32'(nvalid - n0), 32'd1);
        chk("f_req_after", 32'(im.im_req), 32'h0);

        // branch vector table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            goto_pc(vecs[i].pre_pc);
            do_fetch(vecs[i].instr, 1);
            chk($sformatf("v%0d_ir", i), ir, vecs[i].instr);
            chk($sformatf("v%0d_pc_fetch", i), 32'(pc), 32'(16'(vecs[i].pre_pc + 16'd1)));
            n0 = ntaken;
            do_branch(vecs[i].stat);
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_taken", i), 32'(ntaken - n0), 32'(vecs[i].exp_taken));
        end

        // fetch_go and br_go together: fetch uses branched PC one cycle later
        do_reset();
        do_fetch(32'h4100_0100, 0);
        stat = 4'h1;
        fetch_go = 1'b1;
        br_go = 1'b1;
        step();
        fetch_go = 1'b0;
        br_go = 1'b0;
        chk("fb_pc", 32'(pc), 32'h100);
        chk("fb_req0", 32'(im.im_req), 32'h0);
        step();
        chk("fb_req1", 32'(im.im_req), 32'h1);
        chk("fb_addr", 32'(im.im_addr), 32'h100);
        im.im_ack = 1'b1;
        im.im_data = 32'h0000_0000;
        step();
        im.im_ack = 1'b0;
        chk("fb_pc2", 32'(pc), 32'h101);

        // halt blocks further fetches
        do_reset();
        do_fetch(32'hF000_0000, 0);
        chk("h_halted", 32'(halted), 32'h1);
        chk("h_op", 32'(opcode), 32'hF);
        req_cycles = 0;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        if (im.im_req) req_cycles++;
        repeat (3) begin
            step();
            if (im.im_req) req_cycles++;
        end
        chk("h_noreq", 32'(req_cycles), 32'h0);
        chk("h_pc", 32'(pc), 32'h1);

        // asynchronous reset mid-request, late ack ignored
        do_reset();
        do_fetch(32'h0000_0001, 0);
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("r_req_before", 32'(im.im_req), 32'h1);
        rst_f = 1'b0;
        #1;
        chk("r_req_async", 32'(im.im_req), 32'h0);
        chk("r_pc_async", 32'(pc), 32'h0);
        im.im_ack = 1'b1;
        im.im_data = 32'h2200_0000;
        step();
        rst_f = 1'b1;
        n0 = nvalid;
        step();
        im.im_ack = 1'b0;
        im.im_data = 32'h0;
        step();
        chk("r_late_ack", {nvalid - n0}, 32'h0);
        chk("r_ir", ir, 32'h0);
        chk("r_pc", 32'(pc), 32'h0);

        // unacknowledged request: watchdog or indefinite wait
        do_reset();
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        req_cycles = 0;
        for (int k = 0; k < 300; k++) begin
            if (im.im_req) req_cycles++;
            step();
        end
`ifdef IFETCH_TIMEOUT_EN
        chk("to_cycles", 32'(req_cycles), 32'd255);
        chk("to_err", 32'(fetch_err), 32'h1);
        chk("to_idle", 32'(busy), 32'h0);
        chk("to_pc", 32'(pc), 32'h0);
`else
        chk("nt_cycles", 32'(req_cycles), 32'd300);
        chk("nt_err", 32'(fetch_err), 32'h0);
        im.im_ack = 1'b1;
        im.im_data = 32'h3000_0007;
        step();
        im.im_ack = 1'b0;
        chk("nt_ir", ir, 32'h3000_0007);
        chk("nt_pc", 32'(pc), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
